// File: rtl/aln_pkg.sv
// Shared encodings for the alignment datapath: op codes, direction-RAM fields,
// matrix select and the traceback FSM states.
package aln_pkg;

    localparam logic [1:0] OP_M = 2'b00;
    localparam logic [1:0] OP_I = 2'b01;
    localparam logic [1:0] OP_D = 2'b10;

    localparam logic [1:0] V_DIAG   = 2'b00;
    localparam logic [1:0] V_FROM_I = 2'b01;
    localparam logic [1:0] V_FROM_D = 2'b10;
    localparam logic [1:0] V_RSVD   = 2'b11;

    typedef enum logic [1:0] {MAT_V, MAT_I, MAT_D} mat_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_WAIT, ST_DECODE, ST_EMIT, ST_FLUSH, ST_DONE
    } tb_state_t;

endpackage

// File: rtl/traceback_engine.sv
// Walks the affine-gap direction matrix from an end cell back to the origin,
// emitting one alignment op per handshake in end-to-origin order.
module traceback_engine
    import aln_pkg::*;
#(
    parameter int ROWS   = 64,
    parameter int COLS   = 200,
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int COL_W  = $clog2(COLS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ROW_W-1:0]  i_end_row,
    input  logic [COL_W-1:0]  i_end_col,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [3:0]        i_rd_data,
    output logic [1:0]        o_op,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [CNT_W-1:0]  o_op_count
);

    localparam int R_W = $clog2(ROWS + 1);
    localparam int C_W = $clog2(COLS + 1);

    tb_state_t        state, state_nx;
    logic [R_W-1:0]   r, r_pend, dec_r;
    logic [C_W-1:0]   c, c_pend, dec_c;
    mat_t             mat, mat_pend, dec_mat;
    logic [3:0]       dir_q;
    logic [1:0]       op_q, dec_op;
    logic             dec_emit, dec_err;
    logic             error_q;
    logic [CNT_W-1:0] cnt;
    logic             hs;

    assign hs = o_op_valid && i_op_ready;

    // Cell decode; r/c/mat updates are staged and only committed on the handshake.
    always_comb begin
        dec_emit = 1'b0;
        dec_err  = 1'b0;
        dec_op   = OP_M;
        dec_r    = r;
        dec_c    = c;
        dec_mat  = mat;
        case (mat)
            MAT_V: begin
                case (dir_q[1:0])
                    V_DIAG: begin
                        dec_emit = 1'b1;
                        dec_op   = OP_M;
                        dec_r    = r - 1'b1;
                        dec_c    = c - 1'b1;
                    end
                    V_FROM_I: dec_mat = MAT_I;
                    V_FROM_D: dec_mat = MAT_D;
                    default:  dec_err = 1'b1;
                endcase
            end
            MAT_I: begin
                dec_emit = 1'b1;
                dec_op   = OP_I;
                dec_c    = c - 1'b1;
                dec_mat  = dir_q[2] ? MAT_I : MAT_V;
            end
            MAT_D: begin
                dec_emit = 1'b1;
                dec_op   = OP_D;
                dec_r    = r - 1'b1;
                dec_mat  = dir_q[3] ? MAT_D : MAT_V;
            end
            default: dec_mat = MAT_V;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (i_start) state_nx = ST_FETCH;
            ST_FETCH:  state_nx = (r == '0 || c == '0) ? ST_FLUSH : ST_WAIT;
            ST_WAIT:   state_nx = ST_DECODE;
            ST_DECODE: begin
                if (dec_err)       state_nx = ST_DONE;
                else if (dec_emit) state_nx = ST_EMIT;
            end
            ST_EMIT:   if (hs) state_nx = ST_FETCH;
            ST_FLUSH:  if (r == '0 && c == '0) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rd_en    = (state == ST_FETCH) && (r != '0) && (c != '0);
        o_rd_addr  = '0;
        if (o_rd_en)
            o_rd_addr = ADDR_W'(r - 1'b1) * ADDR_W'(COLS) + ADDR_W'(c - 1'b1);
        o_op_valid = (state == ST_EMIT) || ((state == ST_FLUSH) && (r != '0 || c != '0));
        o_op       = OP_M;
        if (state == ST_EMIT)
            o_op = op_q;
        else if (o_op_valid)
            o_op = (r == '0) ? OP_I : OP_D;
        o_busy     = (state != ST_IDLE) && (state != ST_DONE);
        o_done     = (state == ST_DONE);
        o_error    = error_q;
        o_op_count = cnt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r        <= '0;
            c        <= '0;
            mat      <= MAT_V;
            r_pend   <= '0;
            c_pend   <= '0;
            mat_pend <= MAT_V;
            dir_q    <= '0;
            op_q     <= OP_M;
            error_q  <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: if (i_start) begin
                    r       <= R_W'(i_end_row) + R_W'(1);
                    c       <= C_W'(i_end_col) + C_W'(1);
                    mat     <= MAT_V;
                    cnt     <= '0;
                    error_q <= 1'b0;
                end
                ST_WAIT: dir_q <= i_rd_data;
                ST_DECODE: begin
                    if (dec_err) begin
                        error_q <= 1'b1;
                    end else if (dec_emit) begin
                        op_q     <= dec_op;
                        r_pend   <= dec_r;
                        c_pend   <= dec_c;
                        mat_pend <= dec_mat;
                    end else begin
                        mat <= dec_mat;
                    end
                end
                ST_EMIT: if (hs) begin
                    r   <= r_pend;
                    c   <= c_pend;
                    mat <= mat_pend;
                end
                ST_FLUSH: if (hs) begin
                    if (r == '0) c <= c - 1'b1;
                    else         r <= r - 1'b1;
                end
                default: ;
            endcase
            if (hs && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule
